// File: rtl/keypoint_scheduler.sv
// keypoint_scheduler
// Admission controller in front of the rBRIEF pipeline. It filters raw FAST
// corner strobes, issues the pipeline corner strobe, and keeps the (x,y) of
// every admitted corner in a FIFO. When the pipeline reports a descriptor,
// the oldest (x,y) is paired with it and emitted as one keypoint.
module keypoint_scheduler #(
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int DESC_W  = 256,
  parameter int DEPTH   = 8,
  parameter int MIN_GAP = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     corner_in,
  input  logic [X_W-1:0]           corner_x,
  input  logic [Y_W-1:0]           corner_y,
  input  logic                     rb_full,
  input  logic                     rb_valid,
  input  logic [DESC_W-1:0]        rb_desc,
  output logic                     rb_corner,
  output logic                     kp_valid,
  output logic [X_W-1:0]           kp_x,
  output logic [Y_W-1:0]           kp_y,
  output logic [DESC_W-1:0]        kp_desc,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     err_under,
  output logic [$clog2(DEPTH):0]   q_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = X_W + Y_W;
  // Gap counter only has to hold MIN_GAP-1.
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 1) ? (MIN_GAP - 1) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;

  logic q_full, q_empty;
  logic accept, reject, push, pop, under;

  // Saturating increment for the drop counter: sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Admission decision and queue handshakes, all combinational.
  always_comb begin
    q_full  = (level == LVL_FULL);
    q_empty = (level == '0);
    pop     = rb_valid & ~q_empty;
    under   = rb_valid & q_empty;
    // A pop in the same cycle frees a slot, so a full queue can still admit.
    accept  = ena & corner_in & (state == IDLE) & ~rb_full & (~q_full | pop);
    reject  = ena & corner_in & ~accept;
    // Masked by reset so nothing is issued or queued while rst is low.
    push    = accept & rst;
  end

  // The pipeline strobe must stay aligned with the window pixels, so it is not registered.
  assign rb_corner = push;
  assign q_level   = level;

  // Min-gap FSM: next state and gap counter.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (accept && (MIN_GAP > 1)) begin
          state_nxt = GAP;
          gap_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        // Gap only elapses on enabled pixel cycles.
        if (ena) begin
          gap_nxt = gap_cnt - GAP_ONE;
          if (gap_cnt == GAP_ONE) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gap_nxt   = '0;
      end
    endcase
  end

  // Min-gap FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Queue storage: coordinates only, no reset needed since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {corner_y, corner_x};
  end

  // Keypoint output register: one cycle after a pop, fields hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kp_valid <= 1'b0;
      kp_x     <= '0;
      kp_y     <= '0;
      kp_desc  <= '0;
    end else begin
      kp_valid <= pop;
      if (pop) begin
        {kp_y, kp_x} <= mem[rd_ptr];
        kp_desc      <= rb_desc;
      end
    end
  end

  // Rejected-corner counter and sticky underflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt  <= '0;
      err_under <= 1'b0;
    end else begin
      if (reject) drop_cnt <= sat_inc(drop_cnt);
      if (under)  err_under <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypoint_scheduler.sv
// Testbench for keypoint_scheduler (DEPTH=8, MIN_GAP=4, CNT_W=16).
module tb_keypoint_scheduler;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         corner_in;
  logic [10:0]  corner_x;
  logic [9:0]   corner_y;
  logic         rb_full;
  logic         rb_valid;
  logic [255:0] rb_desc;
  logic         rb_corner;
  logic         kp_valid;
  logic [10:0]  kp_x;
  logic [9:0]   kp_y;
  logic [255:0] kp_desc;
  logic [15:0]  drop_cnt;
  logic         err_under;
  logic [3:0]   q_level;

  int checks = 0;
  int fails  = 0;

  keypoint_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .corner_in (corner_in),
    .corner_x  (corner_x),
    .corner_y  (corner_y),
    .rb_full   (rb_full),
    .rb_valid  (rb_valid),
    .rb_desc   (rb_desc),
    .rb_corner (rb_corner),
    .kp_valid  (kp_valid),
    .kp_x      (kp_x),
    .kp_y      (kp_y),
    .kp_desc   (kp_desc),
    .drop_cnt  (drop_cnt),
    .err_under (err_under),
    .q_level   (q_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ena;
    logic         cin;
    logic [10:0]  x;
    logic [9:0]   y;
    logic         full;
    logic         vld;
    logic [255:0] desc;
    logic         e_corner;
    logic         e_kv;
    logic [10:0]  e_x;
    logic [9:0]   e_y;
    logic [255:0] e_desc;
    logic [15:0]  e_drop;
    logic [3:0]   e_lvl;
  } vec_t;

  localparam logic [255:0] DA = {8{32'hAAAA_0001}};
  localparam logic [255:0] DB = {8{32'hBBBB_0002}};
  localparam logic [255:0] DC = {8{32'hCCCC_0003}};
  localparam logic [255:0] DD = {8{32'hDDDD_0004}};
  localparam logic [255:0] DE = {8{32'hEEEE_0005}};

  vec_t tbl [18];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic [10:0] x, input logic [9:0] y,
                       input logic f, input logic v, input logic [255:0] d);
    ena       = e;
    corner_in = c;
    corner_x  = x;
    corner_y  = y;
    rb_full   = f;
    rb_valid  = v;
    rb_desc   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ena cin x y full vld desc | corner kv x y desc drop lvl
    tbl[0]  = '{1,1,11'd5,10'd7,0,0,'0,   1,0,11'd0,10'd0,'0, 16'd0,4'd1};
    tbl[1]  = '{1,1,11'd1,10'd1,0,0,'0,   0,0,11'd0,10'd0,'0, 16'd1,4'd1};
    tbl[2]  = '{1,1,11'd1,10'd1,0,0,'0,   0,0,11'd0,10'd0,'0, 16'd2,4'd1};
    tbl[3]  = '{1,1,11'd1,10'd1,0,0,'0,   0,0,11'd0,10'd0,'0, 16'd3,4'd1};
    tbl[4]  = '{1,1,11'd9,10'd3,0,0,'0,   1,0,11'd0,10'd0,'0, 16'd3,4'd2};
    tbl[5]  = '{1,0,11'd0,10'd0,0,1,DA,   0,1,11'd5,10'd7,DA, 16'd3,4'd1};
    tbl[6]  = '{1,0,11'd0,10'd0,0,1,DB,   0,1,11'd9,10'd3,DB, 16'd3,4'd0};
    tbl[7]  = '{1,0,11'd0,10'd0,0,0,'0,   0,0,11'd9,10'd3,DB, 16'd3,4'd0};
    tbl[8]  = '{1,1,11'd2,10'd2,1,0,'0,   0,0,11'd9,10'd3,DB, 16'd4,4'd0};
    tbl[9]  = '{1,1,11'd4,10'd6,0,0,'0,   1,0,11'd9,10'd3,DB, 16'd4,4'd1};
    tbl[10] = '{0,1,11'd3,10'd3,0,0,'0,   0,0,11'd9,10'd3,DB, 16'd4,4'd1};
    tbl[11] = '{1,0,11'd0,10'd0,0,0,'0,   0,0,11'd9,10'd3,DB, 16'd4,4'd1};
    tbl[12] = '{1,0,11'd0,10'd0,0,0,'0,   0,0,11'd9,10'd3,DB, 16'd4,4'd1};
    tbl[13] = '{1,1,11'd7,10'd7,0,0,'0,   0,0,11'd9,10'd3,DB, 16'd5,4'd1};
    tbl[14] = '{1,1,11'd8,10'd1,0,0,'0,   1,0,11'd9,10'd3,DB, 16'd5,4'd2};
    tbl[15] = '{1,0,11'd0,10'd0,0,1,DC,   0,1,11'd4,10'd6,DC, 16'd5,4'd1};
    tbl[16] = '{1,0,11'd0,10'd0,0,1,DD,   0,1,11'd8,10'd1,DD, 16'd5,4'd0};
    tbl[17] = '{1,0,11'd0,10'd0,0,0,'0,   0,0,11'd8,10'd1,DD, 16'd5,4'd0};

    // Reset with a corner strobe present
    rst = 1'b0;
    drive(1, 1, 11'd5, 10'd5, 0, 0, '0);
    #2;
    chk("reset rb_corner", rb_corner, 0);
    tick();
    chk("reset rb_corner edge", rb_corner, 0);
    chk("reset kp_valid", kp_valid, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    chk("reset q_level", q_level, 0);
    chk("reset err_under", err_under, 0);
    rst = 1'b1;

    // Table: min-gap, pairing, rb_full, ena gating
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ena, tbl[i].cin, tbl[i].x, tbl[i].y, tbl[i].full, tbl[i].vld, tbl[i].desc);
      #1;
      chk($sformatf("v%0d rb_corner", i), rb_corner, tbl[i].e_corner);
      tick();
      chk($sformatf("v%0d kp_valid", i), kp_valid, tbl[i].e_kv);
      chk($sformatf("v%0d kp_x", i), kp_x, tbl[i].e_x);
      chk($sformatf("v%0d kp_y", i), kp_y, tbl[i].e_y);
      chk($sformatf("v%0d kp_desc", i), kp_desc, tbl[i].e_desc);
      chk($sformatf("v%0d drop_cnt", i), drop_cnt, tbl[i].e_drop);
      chk($sformatf("v%0d q_level", i), q_level, tbl[i].e_lvl);
    end

    // Fill the queue to DEPTH
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 11'(i), 10'(i + 10), 0, 0, '0);
      #1;
      chk($sformatf("fill%0d rb_corner", i), rb_corner, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
        drive(1, 0, '0, '0, 0, 0, '0);
        tick();
      end
    end
    chk("full q_level", q_level, 8);

    // Full queue, corner and pop together -> admitted, level stays 8
    drive(1, 1, 11'd20, 10'd21, 0, 1, DE);
    #1;
    chk("full+pop rb_corner", rb_corner, 1);
    tick();
    chk("full+pop q_level", q_level, 8);
    chk("full+pop kp_valid", kp_valid, 1);
    chk("full+pop kp_x", kp_x, 0);
    chk("full+pop kp_y", kp_y, 10);
    chk("full+pop kp_desc", kp_desc, DE);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, '0, '0, 0, 0, '0);
      tick();
    end

    // Full queue, corner without pop -> dropped
    drive(1, 1, 11'd30, 10'd31, 0, 0, '0);
    #1;
    chk("full nopop rb_corner", rb_corner, 0);
    tick();
    chk("full nopop drop_cnt", drop_cnt, 6);
    chk("full nopop q_level", q_level, 8);

    // Drain in FIFO order
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, '0, '0, 0, 1, 256'(i + 100));
      tick();
      chk($sformatf("drain%0d kp_valid", i), kp_valid, 1);
      chk($sformatf("drain%0d kp_x", i), kp_x, (i < 7) ? 11'(i + 1) : 11'd20);
      chk($sformatf("drain%0d kp_y", i), kp_y, (i < 7) ? 10'(i + 11) : 10'd21);
      chk($sformatf("drain%0d kp_desc", i), kp_desc, 256'(i + 100));
      chk($sformatf("drain%0d q_level", i), q_level, 4'(7 - i));
    end
    drive(1, 0, '0, '0, 0, 0, '0);
    tick();
    chk("post drain kp_valid", kp_valid, 0);
    chk("post drain err_under", err_under, 0);

    // Underflow: rb_valid with empty queue
    drive(1, 0, '0, '0, 0, 1, DA);
    tick();
    chk("under kp_valid", kp_valid, 0);
    chk("under err_under", err_under, 1);
    chk("under q_level", q_level, 0);
    drive(1, 0, '0, '0, 0, 0, '0);
    tick();
    chk("under sticky", err_under, 1);

    // Drop counter saturation
    for (int i = 0; i < 65535 - 6; i++) begin
      drive(1, 1, '0, '0, 1, 0, '0);
      tick();
    end
    chk("sat reach", drop_cnt, 16'hFFFF);
    drive(1, 1, '0, '0, 1, 0, '0);
    tick();
    chk("sat hold", drop_cnt, 16'hFFFF);
    chk("sat q_level", q_level, 0);

    // Reset mid-operation flushes queue and clears sticky state
    drive(1, 1, 11'd3, 10'd4, 0, 0, '0);
    tick();
    chk("preflush q_level", q_level, 1);
    drive(1, 0, '0, '0, 0, 0, '0);
    rst = 1'b0;
    #2;
    chk("flush q_level", q_level, 0);
    chk("flush err_under", err_under, 0);
    chk("flush drop_cnt", drop_cnt, 0);
    chk("flush kp_x", kp_x, 0);
    tick();
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
